band_accum: RTL and testbench

//  Downstream stage of the per-band scalers in the equalizer. Captures the NUM_BANDS

---
 rtl/eq_pkg.sv | 19 +
 rtl/sat_trunc.sv | 23 ++
 rtl/band_accum.sv | 94 +++++++++
 tb/tb_band_accum.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared equalizer types and constants: sample format, accumulator FSM states,
// and the saturation rails used wherever a wide result is narrowed to a sample.
package eq_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int DEF_NUM_BANDS = 5;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT
  } accum_state_t;

  localparam sample_t SAT_POS = 16'h7FFF;
  localparam sample_t SAT_NEG = 16'h8000;

endpackage

// File: rtl/sat_trunc.sv
// Combinational saturating narrower: clamps a signed IN_W-bit value to sample_t.
// Reusable by any equalizer stage that widens internally.
module sat_trunc
  import eq_pkg::*;
#(
  parameter int IN_W = SAMPLE_W + 1
) (
  input  logic signed [IN_W-1:0] din,
  output sample_t                dout
);

  localparam int EXTRA = IN_W - SAMPLE_W;

  // The value fits only if every bit above the output sign bit repeats the input sign.
  // NOTE: dout gets its default before the override so no path leaves it unassigned (no latch).
  always_comb begin
    dout = din[SAMPLE_W-1:0];
    if (din[IN_W-1:SAMPLE_W-1] != {(EXTRA+1){din[IN_W-1]}}) begin
      dout = din[IN_W-1] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/band_accum.sv
// Captures a full set of scaled band samples on a strobe, sums them one band per
// clock into a widened accumulator, and emits the saturated total with a valid pulse.
module band_accum
  import eq_pkg::sample_t, eq_pkg::accum_state_t, eq_pkg::IDLE, eq_pkg::ACCUM, eq_pkg::SAT,
         eq_pkg::DEF_NUM_BANDS;
#(
  parameter int NUM_BANDS = DEF_NUM_BANDS,
  parameter int SAMPLE_W  = eq_pkg::SAMPLE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          smpl_vld,
  input  logic [NUM_BANDS*SAMPLE_W-1:0] band_in,
  input  logic                          ovrn_clr,
  output logic [SAMPLE_W-1:0]           eq_out,
  output logic                          out_vld,
  output logic                          busy,
  output logic                          ovrn
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_BANDS);
  localparam int IDX_W = $clog2(NUM_BANDS);

  accum_state_t                state;
  logic        [IDX_W-1:0]     idx;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     band_ext;
  logic signed [SAMPLE_W-1:0]  smpl_q [NUM_BANDS];
  sample_t                     acc_sat;

  // NOTE: the sample register holds data only; it is never read before a capture,
  // so it carries no reset and maps onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (state == IDLE && smpl_vld) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        smpl_q[k] <= band_in[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  assign band_ext = {{(ACC_W-SAMPLE_W){smpl_q[idx][SAMPLE_W-1]}}, smpl_q[idx]};

  sat_trunc #(.IN_W(ACC_W)) u_sat (
    .din  (acc),
    .dout (acc_sat)
  );

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      idx     <= '0;
      eq_out  <= '0;
      out_vld <= 1'b0;
      ovrn    <= 1'b0;
    end else begin
      out_vld <= 1'b0;

      // A dropped strobe outranks a clear so an overrun is never lost.
      if (smpl_vld && state != IDLE) begin
        ovrn <= 1'b1;
      end else if (ovrn_clr) begin
        ovrn <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (smpl_vld) begin
            acc   <= '0;
            idx   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + band_ext;
          idx <= idx + 1'b1;
          if (idx == IDX_W'(NUM_BANDS-1)) begin
            state <= SAT;
          end
        end
        SAT: begin
          eq_out  <= acc_sat;
          out_vld <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_band_accum.sv
// Scoreboard bench for band_accum: expected sums are queued when a sample set is
// accepted and compared when out_vld fires.
module tb_band_accum;

  localparam int NB = 5;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            smpl_vld;
  logic [NB*W-1:0] band_in;
  logic            ovrn_clr;
  logic [W-1:0]    eq_out;
  logic            out_vld;
  logic            busy;
  logic            ovrn;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_count = 0;
  logic prev_vld = 1'b0;
  logic [W-1:0] sb[$];

  band_accum #(.NUM_BANDS(NB), .SAMPLE_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .smpl_vld (smpl_vld),
    .band_in  (band_in),
    .ovrn_clr (ovrn_clr),
    .eq_out   (eq_out),
    .out_vld  (out_vld),
    .busy     (busy),
    .ovrn     (ovrn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_sum(input logic [NB*W-1:0] b);
    int s = 0;
    for (int k = 0; k < NB; k++) s += int'($signed(b[k*W +: W]));
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  function automatic logic [NB*W-1:0] pack_all(input logic [W-1:0] v);
    return {NB{v}};
  endfunction

  function automatic logic [NB*W-1:0] pack5(input int a, input int b, input int c,
                                            input int d, input int e);
    logic [NB*W-1:0] v;
    v[0*W +: W] = 16'(a);
    v[1*W +: W] = 16'(b);
    v[2*W +: W] = 16'(c);
    v[3*W +: W] = 16'(d);
    v[4*W +: W] = 16'(e);
    return v;
  endfunction

  function automatic logic [NB*W-1:0] rand_set(input int mode);
    logic [NB*W-1:0] v;
    for (int k = 0; k < NB; k++) begin
      case (mode)
        0:       v[k*W +: W] = 16'($urandom);
        1:       v[k*W +: W] = 16'(int'($urandom_range(0, 4000)) - 2000);
        2:       v[k*W +: W] = 16'(int'($urandom_range(20000, 32767)));
        default: v[k*W +: W] = 16'(-int'($urandom_range(20000, 32768)));
      endcase
    end
    return v;
  endfunction

  // Output monitor: every out_vld pops one expected sum.
  always @(negedge clk) begin
    if (!rst && out_vld) begin
      vld_count++;
      check("vld_gap", {31'b0, prev_vld}, 32'd0);
      if (sb.size() == 0) check("unexpected_vld", {31'b0, out_vld}, 32'd0);
      else check("eq_out", {16'b0, eq_out}, {16'b0, sb.pop_front()});
    end
    prev_vld = out_vld;
  end

  // Called just after a posedge; returns just after the edge that samples the strobe.
  task automatic drive_sample(input logic [NB*W-1:0] bands, input bit accept);
    band_in  = bands;
    smpl_vld = 1'b1;
    if (accept) sb.push_back(model_sum(bands));
    @(posedge clk); #1;
    smpl_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    check("idle_timeout", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int busy_cyc;
    int vld_at;

    rst = 1'b1; smpl_vld = 1'b0; ovrn_clr = 1'b0; band_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_eq_out", {16'b0, eq_out}, 32'd0);
    check("rst_out_vld", {31'b0, out_vld}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovrn", {31'b0, ovrn}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sum with latency and busy-width measurement.
    n0 = vld_count; busy_cyc = 0; vld_at = 0;
    drive_sample(pack_all(16'h03E8), 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (out_vld && vld_at == 0) vld_at = c;
    end
    check("t1_busy_cycles", busy_cyc, 32'd6);
    check("t1_latency", vld_at, 32'd7);
    check("t1_vld_count", vld_count - n0, 32'd1);
    check("t1_eq_out_held", {16'b0, eq_out}, 32'h1388);
    @(posedge clk); #1;

    // Saturation rails.
    drive_sample(pack_all(16'h7FFF), 1'b1);
    wait_idle();
    drive_sample(pack_all(16'h8000), 1'b1);
    wait_idle();

    // Mixed signs, with band_in corrupted right after capture.
    drive_sample(pack5(100, -100, 200, -200, 7), 1'b1);
    band_in = pack_all(16'h7FFF);
    wait_idle();
    check("capture_isolation", {16'b0, eq_out}, 32'd7);

    // Overrun: drop during ACCUM, then clear racing a second drop.
    n0 = vld_count;
    drive_sample(pack5(1, 2, 3, 4, 5), 1'b1);
    drive_sample(pack_all(16'h1234), 1'b0);
    @(negedge clk);
    check("ovrn_set", {31'b0, ovrn}, 32'd1);
    @(posedge clk); #1;
    ovrn_clr = 1'b1;
    drive_sample(pack_all(16'h4321), 1'b0);
    ovrn_clr = 1'b0;
    @(negedge clk);
    check("ovrn_set_wins", {31'b0, ovrn}, 32'd1);
    wait_idle();
    check("ovrn_single_vld", vld_count - n0, 32'd1);
    ovrn_clr = 1'b1;
    @(posedge clk); #1;
    ovrn_clr = 1'b0;
    @(negedge clk);
    check("ovrn_clr", {31'b0, ovrn}, 32'd0);
    @(posedge clk); #1;

    // Strobe coincident with out_vld is accepted.
    n0 = vld_count;
    drive_sample(pack5(-5, -6, -7, -8, -9), 1'b1);
    vld_at = 0;
    for (int i = 0; i < 20 && vld_at == 0; i++) begin
      @(negedge clk);
      if (out_vld) vld_at = 1;
    end
    check("coinc_vld_seen", vld_at, 32'd1);
    band_in  = pack5(1000, 2000, 3000, 4000, 5000);
    smpl_vld = 1'b1;
    sb.push_back(model_sum(band_in));
    @(posedge clk); #1;
    smpl_vld = 1'b0;
    wait_idle();
    check("coinc_no_ovrn", {31'b0, ovrn}, 32'd0);
    check("coinc_vld_count", vld_count - n0, 32'd2);

    // Reset on the third ACCUM cycle aborts the sum.
    n0 = vld_count;
    drive_sample(pack_all(16'h0100), 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_eq_out", {16'b0, eq_out}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_vld", vld_count - n0, 32'd0);
    drive_sample(pack5(10, 20, 30, 40, 50), 1'b1);
    wait_idle();
    check("after_abort_sum", {16'b0, eq_out}, 32'd150);

    // Back-to-back random stream at full throughput.
    n0 = vld_count;
    for (int i = 0; i < 100; i++) begin
      drive_sample(rand_set(i % 4), 1'b1);
      repeat (6) @(posedge clk);
      #1;
    end
    wait_idle();
    check("stream_vld_count", vld_count - n0, 32'd100);
    check("stream_no_ovrn", {31'b0, ovrn}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
